reaction_stopwatch: RTL and testbench

Timing core of the game. It measures one trial in milliseconds and publishes the finished result to the leaderboard stage as a 22-bit time plus the latched stopwatch mode. It also drives a live elapsed count for the seven-segment display path. In fast mode it inserts a randomized "get ready" delay before the go LED lights, and it flags false starts.

---
 rtl/stopwatch_pkg.sv | 31 +++
 rtl/lfsr16.sv | 29 ++
 rtl/reaction_stopwatch.sv | 151 +++++++++++++++
 tb/tb_reaction_stopwatch.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch and the leaderboard stage.
package stopwatch_pkg;

  localparam int unsigned TIME_W = 22;
  localparam logic [TIME_W-1:0] TIME_MAX = 22'h3FFFFF;

  localparam logic [1:0] MODE_SLOW = 2'b01;
  localparam logic [1:0] MODE_FAST = 2'b10;

  localparam logic [12:0] DELAY_MIN = 13'd1024;
  localparam logic [12:0] DELAY_MAX = 13'd4095;

  typedef enum logic [2:0] {
    StIdle,
    StArmed,
    StRunning,
    StDone,
    StFalseStart
  } sw_state_e;

  function automatic logic mode_valid(input logic [1:0] mode);
    return (mode == MODE_SLOW) || (mode == MODE_FAST);
  endfunction

  function automatic logic [12:0] clamp_delay(input logic [12:0] raw);
    if (raw < DELAY_MIN) return DELAY_MIN;
    if (raw > DELAY_MAX) return DELAY_MAX;
    return raw;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit maximal-length Fibonacci LFSR (x^16 + x^14 + x^13 + x^11 + 1).
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic [15:0] lfsr
);

  logic [15:0] lfsr_q, lfsr_d;
  logic        feedback;

  always_comb begin
    feedback = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
    lfsr_d   = en ? {feedback, lfsr_q[15:1]} : lfsr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lfsr = lfsr_q;

endmodule

// File: rtl/reaction_stopwatch.sv
// Trial timer: prescaled ms counter, optional go delay, false-start detection, result publish.
// Define RANDOM_DELAY_EN to draw the fast-mode go delay from an LFSR instead of FIXED_DELAY_MS.
module reaction_stopwatch
  import stopwatch_pkg::*;
#(
  parameter int unsigned CLK_HZ         = 100_000_000,
  parameter int unsigned TICK_HZ        = 1000,
  parameter int unsigned FIXED_DELAY_MS = 2000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_btn,
  input  logic              stop_btn,
  input  logic [1:0]        stopwatch_mode,
  output logic [TIME_W-1:0] time_out,
  output logic              time_valid,
  output logic [1:0]        mode_out,
  output logic [TIME_W-1:0] elapsed,
  output logic              running,
  output logic              go_led,
  output logic              false_start
);

  localparam int unsigned DIV     = (CLK_HZ / TICK_HZ < 1) ? 1 : CLK_HZ / TICK_HZ;
  localparam int unsigned PRESC_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(DIV - 1);

  sw_state_e         state_q, state_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [TIME_W-1:0] delay_q, delay_d;
  logic [TIME_W-1:0] elapsed_q, elapsed_d;
  logic [TIME_W-1:0] time_q, time_d;
  logic [1:0]        mode_q, mode_d;
  logic [1:0]        mode_out_q, mode_out_d;
  logic              valid_q, valid_d;

  logic              tick;
  logic              start_ok;
  logic [TIME_W-1:0] elapsed_inc;
  logic [TIME_W-1:0] delay_load;

`ifdef RANDOM_DELAY_EN
  logic [15:0] lfsr;
  logic [12:0] rnd_sum;
  logic        unused_lfsr;

  lfsr16 #(
    .SEED(16'hACE1)
  ) u_lfsr (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (1'b1),
    .lfsr (lfsr)
  );

  // {01, r[9:0]} spans 1024..2047; the r[11:10] offset widens it, the clamp caps it at 4095.
  assign rnd_sum     = {3'b001, lfsr[9:0]} + {1'b0, lfsr[11:10], 10'd0};
  assign delay_load  = TIME_W'(clamp_delay(rnd_sum));
  assign unused_lfsr = ^lfsr[15:12];
`else
  assign delay_load = TIME_W'(FIXED_DELAY_MS);
`endif

  assign tick        = (presc_q == PRESC_LAST);
  assign start_ok    = start_btn && mode_valid(stopwatch_mode);
  assign elapsed_inc = (elapsed_q == TIME_MAX) ? TIME_MAX : elapsed_q + TIME_W'(1);

  always_comb begin
    state_d    = state_q;
    presc_d    = '0;
    delay_d    = delay_q;
    elapsed_d  = elapsed_q;
    time_d     = time_q;
    mode_d     = mode_q;
    mode_out_d = mode_out_q;
    valid_d    = 1'b0;

    unique case (state_q)
      StIdle, StFalseStart: begin
        if (start_ok) begin
          mode_d    = stopwatch_mode;
          elapsed_d = '0;
          delay_d   = delay_load;
          state_d   = (stopwatch_mode == MODE_FAST) ? StArmed : StRunning;
        end
      end
      StArmed: begin
        presc_d = tick ? '0 : presc_q + PRESC_W'(1);
        if (stop_btn) begin
          state_d = StFalseStart;
          presc_d = '0;
        end else if (tick) begin
          // Prescaler wraps to 0 on this tick, so RUNNING starts a fresh ms period.
          if (delay_q <= TIME_W'(1)) begin
            state_d = StRunning;
          end else begin
            delay_d = delay_q - TIME_W'(1);
          end
        end
      end
      StRunning: begin
        presc_d = tick ? '0 : presc_q + PRESC_W'(1);
        if (tick) elapsed_d = elapsed_inc;
        if (stop_btn) begin
          state_d    = StDone;
          presc_d    = '0;
          time_d     = elapsed_d;
          mode_out_d = mode_q;
          valid_d    = 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      presc_q    <= '0;
      delay_q    <= '0;
      elapsed_q  <= '0;
      time_q     <= '0;
      mode_q     <= '0;
      mode_out_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      delay_q    <= delay_d;
      elapsed_q  <= elapsed_d;
      time_q     <= time_d;
      mode_q     <= mode_d;
      mode_out_q <= mode_out_d;
      valid_q    <= valid_d;
    end
  end

  assign time_out    = time_q;
  assign time_valid  = valid_q;
  assign mode_out    = mode_out_q;
  assign elapsed     = elapsed_q;
  assign running     = (state_q == StArmed) || (state_q == StRunning);
  assign go_led      = (state_q == StRunning) && (mode_q == MODE_FAST);
  assign false_start = (state_q == StFalseStart);

endmodule

// File: tb/tb_reaction_stopwatch.sv
// Self-checking bench for reaction_stopwatch: directed scenarios plus randomized trials.
module tb_reaction_stopwatch;
  import stopwatch_pkg::*;

  localparam int unsigned CLK_HZ  = 1000;
  localparam int unsigned TICK_HZ = 100;
  localparam int unsigned FIXED   = 5;
  localparam int          DIV     = CLK_HZ / TICK_HZ;
  localparam int          GO_BUDGET = 50000;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start_btn = 1'b0;
  logic              stop_btn = 1'b0;
  logic [1:0]        stopwatch_mode = 2'b00;
  logic [TIME_W-1:0] time_out;
  logic              time_valid;
  logic [1:0]        mode_out;
  logic [TIME_W-1:0] elapsed;
  logic              running;
  logic              go_led;
  logic              false_start;

  int errors = 0;
  int checks = 0;
  int tv_count = 0;
  logic go_seen = 1'b0;

  reaction_stopwatch #(
    .CLK_HZ        (CLK_HZ),
    .TICK_HZ       (TICK_HZ),
    .FIXED_DELAY_MS(FIXED)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start_btn     (start_btn),
    .stop_btn      (stop_btn),
    .stopwatch_mode(stopwatch_mode),
    .time_out      (time_out),
    .time_valid    (time_valid),
    .mode_out      (mode_out),
    .elapsed       (elapsed),
    .running       (running),
    .go_led        (go_led),
    .false_start   (false_start)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (time_valid) tv_count <= tv_count + 1;
    if (go_led) go_seen <= 1'b1;
  end

  // Reference: ms count for a stop sampled `cycles` edges after the count began.
  function automatic logic [TIME_W-1:0] model_ms(input longint base, input int cycles);
    longint v;
    v = base + cycles / DIV;
    if (v > longint'(TIME_MAX)) v = longint'(TIME_MAX);
    return TIME_W'(v);
  endfunction

  // Advance n cycles; inputs change and outputs are read at negedge + 1.
  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic do_start(input logic [1:0] mode);
    stopwatch_mode = mode;
    start_btn = 1'b1;
    cyc(1);
    start_btn = 1'b0;
  endtask

  // Stop sampled n edges after the current reference edge.
  task automatic stop_after(input int n);
    cyc(n - 1);
    stop_btn = 1'b1;
    cyc(1);
    stop_btn = 1'b0;
  endtask

  task automatic wait_go(output int c);
    c = 0;
    while (!go_led && c < GO_BUDGET) begin
      cyc(1);
      c++;
    end
  endtask

  task automatic check_publish(input string name, input int tv_before,
                               input logic [TIME_W-1:0] exp_t, input logic [1:0] exp_m);
    checks++;
    if (time_valid !== 1'b1 || time_out !== exp_t || mode_out !== exp_m) begin
      errors++;
      $display("FAIL %s publish: valid=%b time=%0d mode=%b, required valid=1 time=%0d mode=%b",
               name, time_valid, time_out, mode_out, exp_t, exp_m);
    end
    cyc(1);
    checks++;
    if (time_valid !== 1'b0 || tv_count != tv_before + 1) begin
      errors++;
      $display("FAIL %s strobe: valid=%b strobes=%0d, required valid=0 strobes=%0d",
               name, time_valid, tv_count - tv_before, 1);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cyc(2);
    checks++;
    if ({time_out, time_valid, mode_out, elapsed, running, go_led, false_start} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: time=%0d valid=%b mode=%b elapsed=%0d run=%b go=%b fs=%b, required all 0",
               time_out, time_valid, mode_out, elapsed, running, go_led, false_start);
    end
    rst_n = 1'b1;
    cyc(2);
  endtask

  task automatic test_slow();
    int tv0;
    tv0 = tv_count;
    go_seen = 1'b0;
    do_start(MODE_SLOW);
    checks++;
    if (running !== 1'b1) begin
      errors++;
      $display("FAIL slow_start: running=%b, required 1", running);
    end
    stop_after(250);
    check_publish("slow", tv0, model_ms(0, 250), MODE_SLOW);
    checks++;
    if (go_seen !== 1'b0) begin
      errors++;
      $display("FAIL slow_go_led: go_led seen=%b, required 0", go_seen);
    end
  endtask

  task automatic test_fast_fixed();
    int tv0, c;
    tv0 = tv_count;
    do_start(MODE_FAST);
    checks++;
    if (running !== 1'b1 || go_led !== 1'b0) begin
      errors++;
      $display("FAIL fast_armed: running=%b go=%b, required running=1 go=0", running, go_led);
    end
    wait_go(c);
    checks++;
`ifdef RANDOM_DELAY_EN
    if (c % DIV != 0 || c / DIV < 1024 || c / DIV > 4095) begin
      errors++;
      $display("FAIL fast_go_delay: %0d cycles, required multiple of %0d in 1024..4095 ticks",
               c, DIV);
    end
`else
    if (c != int'(FIXED) * DIV) begin
      errors++;
      $display("FAIL fast_go_delay: %0d cycles, required %0d", c, int'(FIXED) * DIV);
    end
`endif
    stop_after(73);
    check_publish("fast", tv0, model_ms(0, 73), MODE_FAST);
  endtask

  task automatic test_false_start();
    int tv0;
    logic [TIME_W-1:0] t0;
    tv0 = tv_count;
    t0  = time_out;
    do_start(MODE_FAST);
    stop_after(20);
    checks++;
    if (false_start !== 1'b1 || running !== 1'b0 || time_valid !== 1'b0) begin
      errors++;
      $display("FAIL false_start_flag: fs=%b run=%b valid=%b, required fs=1 run=0 valid=0",
               false_start, running, time_valid);
    end
    cyc(3);
    checks++;
    if (tv_count != tv0 || time_out !== t0) begin
      errors++;
      $display("FAIL false_start_nopub: strobes=%0d time=%0d, required strobes=0 time=%0d",
               tv_count - tv0, time_out, t0);
    end
    do_start(MODE_SLOW);
    checks++;
    if (false_start !== 1'b0 || running !== 1'b1) begin
      errors++;
      $display("FAIL false_start_clear: fs=%b run=%b, required fs=0 run=1", false_start, running);
    end
    stop_after(30);
    check_publish("after_false_start", tv0, model_ms(0, 30), MODE_SLOW);
  endtask

  task automatic test_invalid_mode();
    logic [1:0] bad [2];
    bad[0] = 2'b00;
    bad[1] = 2'b11;
    foreach (bad[i]) begin
      do_start(bad[i]);
      cyc(2);
      checks++;
      if (running !== 1'b0 || false_start !== 1'b0 || go_led !== 1'b0) begin
        errors++;
        $display("FAIL invalid_mode_%b: run=%b fs=%b go=%b, required all 0",
                 bad[i], running, false_start, go_led);
      end
    end
  endtask

  task automatic test_mode_switch();
    int tv0;
    tv0 = tv_count;
    go_seen = 1'b0;
    do_start(MODE_SLOW);
    stopwatch_mode = MODE_FAST;
    stop_after(120);
    check_publish("mode_switch", tv0, model_ms(0, 120), MODE_SLOW);
    checks++;
    if (go_seen !== 1'b0) begin
      errors++;
      $display("FAIL mode_switch_go: go_led seen=%b, required 0", go_seen);
    end
  endtask

  task automatic test_saturation();
    int tv0;
    logic [TIME_W-1:0] base;
    tv0  = tv_count;
    base = TIME_MAX - 22'd2;
    do_start(MODE_SLOW);
    cyc(2);
    force dut.elapsed_q = base;
    #1;
    release dut.elapsed_q;
    cyc(28);
    checks++;
    if (elapsed !== model_ms(longint'(base), 30)) begin
      errors++;
      $display("FAIL saturation_hold: elapsed=%h, required %h", elapsed,
               model_ms(longint'(base), 30));
    end
    cyc(14);
    stop_btn = 1'b1;
    cyc(1);
    stop_btn = 1'b0;
    check_publish("saturation", tv0, model_ms(longint'(base), 45), MODE_SLOW);
  endtask

  task automatic test_reset_mid_run();
    int tv0;
    tv0 = tv_count;
    do_start(MODE_SLOW);
    cyc(40);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({time_out, time_valid, mode_out, elapsed, running, go_led, false_start} !== '0) begin
      errors++;
      $display("FAIL reset_mid_run: time=%0d valid=%b mode=%b elapsed=%0d run=%b go=%b fs=%b, required all 0",
               time_out, time_valid, mode_out, elapsed, running, go_led, false_start);
    end
    cyc(2);
    rst_n = 1'b1;
    cyc(3);
    checks++;
    if (tv_count != tv0 || running !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_publish: strobes=%0d run=%b, required strobes=0 run=0",
               tv_count - tv0, running);
    end
  endtask

  task automatic test_back_to_back();
    int tv0;
    for (int k = 0; k < 2; k++) begin
      tv0 = tv_count;
      // Start and stop together in IDLE: only start acts.
      stop_btn = 1'b1;
      do_start(MODE_SLOW);
      stop_btn = 1'b0;
      checks++;
      if (running !== 1'b1 || time_valid !== 1'b0) begin
        errors++;
        $display("FAIL b2b_idle_both_%0d: run=%b valid=%b, required run=1 valid=0",
                 k, running, time_valid);
      end
      // Start and stop together in RUNNING: only stop acts.
      cyc(149);
      start_btn = 1'b1;
      stop_btn  = 1'b1;
      cyc(1);
      start_btn = 1'b0;
      stop_btn  = 1'b0;
      check_publish("b2b", tv0, model_ms(0, 150), MODE_SLOW);
    end
  endtask

  task automatic test_random();
    int tv0, n, c, trials;
    logic [1:0] m;
    logic [TIME_W-1:0] t0;
`ifdef RANDOM_DELAY_EN
    trials = 6;
`else
    trials = 12;
`endif
    for (int k = 0; k < trials; k++) begin
      tv0 = tv_count;
      t0  = time_out;
      m   = ($urandom_range(0, 1) == 0) ? MODE_SLOW : MODE_FAST;
`ifdef RANDOM_DELAY_EN
      if (k > 0) m = MODE_SLOW;
`endif
      do_start(m);
      if (m == MODE_SLOW) begin
        n = $urandom_range(1, 300);
        stop_after(n);
        check_publish("rand_slow", tv0, model_ms(0, n), MODE_SLOW);
      end else if ($urandom_range(0, 2) == 0) begin
        n = $urandom_range(1, int'(FIXED) * DIV - 1);
        stop_after(n);
        cyc(1);
        checks++;
        if (false_start !== 1'b1 || tv_count != tv0 || time_out !== t0) begin
          errors++;
          $display("FAIL rand_false_start: fs=%b strobes=%0d time=%0d, required fs=1 strobes=0 time=%0d",
                   false_start, tv_count - tv0, time_out, t0);
        end
      end else begin
        wait_go(c);
        checks++;
        if (c >= GO_BUDGET) begin
          errors++;
          $display("FAIL rand_go_timeout: waited %0d cycles, required go_led", c);
        end
        n = $urandom_range(1, 200);
        stop_after(n);
        check_publish("rand_fast", tv0, model_ms(0, n), MODE_FAST);
      end
    end
  endtask

  initial begin
    test_reset();
    test_slow();
    test_fast_fixed();
    test_false_start();
    test_invalid_mode();
    test_mode_switch();
    test_saturation();
    test_back_to_back();
    test_random();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
